// File: rtl/fpu_test_pkg.sv
// fpu_test_pkg: shared types and defaults for the replicated-FPU test harness.
//   seq_state_t  - run-controller states of fpu_lane_sequencer
//   DEF_*        - default address width, lane count and result word width
//   READY_BIT    - position of the ready flag inside a lane result word
package fpu_test_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_LANES  = 8;
    localparam int unsigned DEF_RES_W  = 70;
    localparam int unsigned READY_BIT  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_ADVANCE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/ready_edge.sv
// ready_edge: registered rising-edge detector with synchronous clear.
//   clk  - rising-edge clock
//   clr  - synchronous clear of the history bit and the edge output
//   d    - level to watch
//   rise - one-cycle pulse, registered, one cycle after d goes 0 -> 1
module ready_edge (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic rise
);

    logic d_q;

    // The history bit follows d every cycle, so a level that stays high
    // never produces a second pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/fpu_lane_sequencer.sv
// fpu_lane_sequencer: bounded run controller for the replicated-FPU harness.
// Steps the shared ROM/RAM address, issues one fpu_en per vector, waits for
// the lane-0 ready edge (or a timeout), cross-checks all lanes against lane 0
// and strobes the lane result RAMs.
//   clk, rst        - clock, synchronous active-high reset
//   start           - run request, honoured only in IDLE/DONE
//   addr            - shared vector address
//   fpu_en          - one-cycle enable to all lanes per vector
//   lane_ready      - per-lane ready bits
//   lane_result     - per-lane result words, lane 0 in the LSBs
//   wr_en           - one-cycle write strobe to the lane RAMs per vector
//   busy, done      - run in progress / run complete (held)
//   mismatch_cnt    - saturating count of vectors with lane disagreement
//   timeout_cnt     - saturating count of vectors that timed out
//   fail_valid      - first failing vector has been captured
//   first_fail_addr - address of the first mismatch or timeout
module fpu_lane_sequencer
    import fpu_test_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned NUM_VEC = 4096,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned RES_W   = DEF_RES_W,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [ADDR_W-1:0]      addr,
    output logic                   fpu_en,
    input  logic [LANES-1:0]       lane_ready,
    input  logic [LANES*RES_W-1:0] lane_result,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        mismatch_cnt,
    output logic [ADDR_W:0]        timeout_cnt,
    output logic                   fail_valid,
    output logic [ADDR_W-1:0]      first_fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_VEC - 1);
    localparam logic [1:0]        FETCH_LAST = 2'(ROM_LAT - 1);
    localparam logic [9:0]        TMO_LOAD   = 10'(TIMEOUT);

    seq_state_t       state_q, state_d;
    logic [1:0]       wait_q;
    logic [9:0]       tmo_q;
    logic             to_seen;
    logic             mis_q, to_q;
    logic             rise;
    logic [LANES-1:0] lane_ok;
    logic             any_mis;

    ready_edge u_ready_edge (
        .clk  (clk),
        .clr  (rst),
        .d    (lane_ready[0]),
        .rise (rise)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_ok[i] = lane_ready[i] &&
                            (lane_result[i*RES_W +: RES_W] == lane_result[RES_W-1:0]);
    end

    assign any_mis = ~&lane_ok;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fpu_en  = 1'b0;
        wr_en   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_FETCH;
            end
            S_FETCH:   if (wait_q == FETCH_LAST) state_d = S_ISSUE;
            S_ISSUE: begin
                fpu_en  = 1'b1;
                state_d = S_WAIT;
            end
            // Edge wins over an expiring counter in the same cycle.
            S_WAIT:    if (rise || tmo_q == 10'd1) state_d = S_CHECK;
            S_CHECK:   state_d = S_WRITE;
            S_WRITE: begin
                wr_en   = 1'b1;
                state_d = S_ADVANCE;
            end
            S_ADVANCE: state_d = (addr == LAST_ADDR) ? S_DONE : S_FETCH;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_d = S_FETCH;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr            <= '0;
            wait_q          <= '0;
            tmo_q           <= '0;
            to_seen         <= 1'b0;
            mis_q           <= 1'b0;
            to_q            <= 1'b0;
            mismatch_cnt    <= '0;
            timeout_cnt     <= '0;
            fail_valid      <= 1'b0;
            first_fail_addr <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        addr         <= '0;
                        wait_q       <= '0;
                        mismatch_cnt <= '0;
                        timeout_cnt  <= '0;
                        fail_valid   <= 1'b0;
                    end
                end
                S_FETCH: wait_q <= wait_q + 2'd1;
                S_ISSUE: begin
                    tmo_q   <= TMO_LOAD;
                    to_seen <= 1'b0;
                end
                S_WAIT: begin
                    if (!rise) begin
                        tmo_q <= tmo_q - 10'd1;
                        if (tmo_q == 10'd1) to_seen <= 1'b1;
                    end
                end
                // A timed-out vector is charged to timeout_cnt only.
                S_CHECK: begin
                    mis_q <= any_mis & ~to_seen;
                    to_q  <= to_seen;
                end
                S_ADVANCE: begin
                    if (mis_q && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (to_q && timeout_cnt != '1)   timeout_cnt  <= timeout_cnt + 1'b1;
                    if ((mis_q || to_q) && !fail_valid) begin
                        fail_valid      <= 1'b1;
                        first_fail_addr <= addr;
                    end
                    if (addr != LAST_ADDR) addr <= addr + 1'b1;
                    wait_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_lane_sequencer.sv
// tb_fpu_lane_sequencer: randomized self-checking bench for fpu_lane_sequencer.
// A lane model answers each fpu_en according to a per-vector descriptor
// (response delay, corrupted lane, lane left not-ready); expected counts,
// failure capture and per-vector cycle counts come from the descriptors.
// A second instance with NUM_VEC = 2^ADDR_W shares the stimulus.
module tb_fpu_lane_sequencer;
    import fpu_test_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int NUM_VEC = 4;
    localparam int LANES   = 8;
    localparam int RES_W   = 70;
    localparam int ROM_LAT = 1;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [ADDR_W-1:0]      addr;
    logic                   fpu_en;
    logic [LANES-1:0]       lane_ready;
    logic [LANES*RES_W-1:0] lane_result;
    logic                   wr_en, busy, done, fail_valid;
    logic [ADDR_W:0]        mismatch_cnt, timeout_cnt;
    logic [ADDR_W-1:0]      first_fail_addr;

    logic [1:0] u2_addr, u2_ffa;
    logic       u2_fpu_en, u2_wr_en, u2_busy, u2_done, u2_fv;
    logic [2:0] u2_mcnt, u2_tcnt;

    fpu_lane_sequencer #(
        .ADDR_W(ADDR_W), .NUM_VEC(NUM_VEC), .LANES(LANES), .RES_W(RES_W),
        .ROM_LAT(ROM_LAT), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .fpu_en(fpu_en),
        .lane_ready(lane_ready), .lane_result(lane_result), .wr_en(wr_en),
        .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
        .timeout_cnt(timeout_cnt), .fail_valid(fail_valid),
        .first_fail_addr(first_fail_addr)
    );

    fpu_lane_sequencer #(
        .ADDR_W(2), .NUM_VEC(4), .LANES(LANES), .RES_W(RES_W),
        .ROM_LAT(ROM_LAT), .TIMEOUT(TIMEOUT)
    ) u_dut_full (
        .clk(clk), .rst(rst), .start(start), .addr(u2_addr), .fpu_en(u2_fpu_en),
        .lane_ready(lane_ready), .lane_result(lane_result), .wr_en(u2_wr_en),
        .busy(u2_busy), .done(u2_done), .mismatch_cnt(u2_mcnt),
        .timeout_cnt(u2_tcnt), .fail_valid(u2_fv), .first_fail_addr(u2_ffa)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-vector descriptors: d_arr = ready delay (0 = never), bad_lane /
    // drop_lane = 0 for none.
    int d_arr[NUM_VEC];
    int bad_lane[NUM_VEC];
    int bad_bit[NUM_VEC];
    int drop_lane[NUM_VEC];
    bit stuck0;
    int lane_vec;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane model: ready drops when fpu_en is seen and rises d cycles after
    // the lanes sample fpu_en, with fresh results on every lane.
    initial begin : lane_model
        int rem;
        int v;
        logic [RES_W-1:0] base, w;
        lane_ready  = '0;
        lane_result = '0;
        rem = 0;
        v   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (fpu_en) begin
                v = lane_vec % NUM_VEC;
                lane_vec++;
                lane_ready = '0;
                rem = (d_arr[v] == 0) ? 0 : d_arr[v] + 1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    base = RES_W'({$urandom, $urandom, $urandom});
                    base[READY_BIT] = 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        w = base;
                        if (i != 0 && i == bad_lane[v]) w[bad_bit[v]] = ~w[bad_bit[v]];
                        lane_result[i*RES_W +: RES_W] = w;
                        lane_ready[i] = (i == 0) || (i != drop_lane[v]);
                    end
                end
            end
            if (stuck0) lane_ready[0] = 1'b1;
        end
    end

    task automatic set_ideal();
        for (int v = 0; v < NUM_VEC; v++) begin
            d_arr[v] = 3; bad_lane[v] = 0; bad_bit[v] = 0; drop_lane[v] = 0;
        end
        stuck0 = 1'b0;
    endtask

    task automatic set_random();
        for (int v = 0; v < NUM_VEC; v++) begin
            d_arr[v]     = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8));
            bad_lane[v]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LANES-1)) : 0;
            bad_bit[v]   = int'($urandom_range(0, RES_W-1));
            drop_lane[v] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LANES-1)) : 0;
        end
        stuck0 = ($urandom_range(0, 7) == 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full run; mid_start pulses start while the run is in progress.
    task automatic run_vectors(input string name, input bit mid_start);
        int exp_k[NUM_VEC];
        int exp_mcnt, exp_tcnt, exp_ffa, nfe, nwr, last_fe;
        bit exp_fv, to, mis, done_seen;

        exp_mcnt = 0; exp_tcnt = 0; exp_ffa = 0; exp_fv = 1'b0;
        for (int v = 0; v < NUM_VEC; v++) begin
            // k = ready delay + 1 sampling cycle + 1 registered-edge cycle
            to = stuck0 || d_arr[v] == 0 || d_arr[v] + 2 > TIMEOUT;
            exp_k[v] = to ? TIMEOUT : d_arr[v] + 2;
            mis = !to && (bad_lane[v] != 0 || drop_lane[v] != 0);
            if (to) exp_tcnt++;
            if (mis) exp_mcnt++;
            if ((to || mis) && !exp_fv) begin exp_fv = 1'b1; exp_ffa = v; end
        end

        lane_vec = 0;
        pulse_start();
        check_eq({name, ".start_busy"}, busy, 1);
        check_eq({name, ".start_done"}, done, 0);
        check_eq({name, ".start_mcnt"}, mismatch_cnt, 0);
        check_eq({name, ".start_tcnt"}, timeout_cnt, 0);
        check_eq({name, ".start_fv"}, fail_valid, 0);
        check_eq({name, ".start_addr"}, addr, 0);

        nfe = 0; nwr = 0; last_fe = 0; done_seen = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (fpu_en) begin
                if (nfe > 0)
                    check_eq($sformatf("%s.period%0d", name, nfe-1), cyc - last_fe,
                             ROM_LAT + 1 + exp_k[nfe-1] + 3);
                check_eq($sformatf("%s.fe_addr%0d", name, nfe), addr, nfe);
                last_fe = cyc;
                nfe++;
            end
            if (wr_en) begin
                check_eq($sformatf("%s.wr_addr%0d", name, nwr), addr, nwr);
                check_eq($sformatf("%s.wr_fe%0d", name, nwr), fpu_en, 0);
                nwr++;
            end
            if (done) begin
                check_eq({name, ".last_period"}, cyc - last_fe, exp_k[NUM_VEC-1] + 4);
                done_seen = 1'b1;
                break;
            end
            start = mid_start && (cyc == 15);
            @(negedge clk);
        end
        start = 1'b0;

        check_eq({name, ".done_seen"}, done_seen, 1);
        check_eq({name, ".n_fpu_en"}, nfe, NUM_VEC);
        check_eq({name, ".n_wr_en"}, nwr, NUM_VEC);
        check_eq({name, ".busy_end"}, busy, 0);
        check_eq({name, ".addr_end"}, addr, NUM_VEC-1);
        check_eq({name, ".mcnt"}, mismatch_cnt, exp_mcnt);
        check_eq({name, ".tcnt"}, timeout_cnt, exp_tcnt);
        check_eq({name, ".fv"}, fail_valid, exp_fv);
        if (exp_fv) check_eq({name, ".ffa"}, first_fail_addr, exp_ffa);
        check_eq({name, ".full_done"}, u2_done, 1);
        check_eq({name, ".full_addr"}, u2_addr, 3);
        check_eq({name, ".full_mcnt"}, u2_mcnt, exp_mcnt);
        check_eq({name, ".full_tcnt"}, u2_tcnt, exp_tcnt);
        repeat (3) @(negedge clk);
        check_eq({name, ".done_held"}, done, 1);
    endtask

    initial begin
        int nfe;
        rst = 1'b1;
        start = 1'b0;
        lane_vec = 0;
        set_ideal();
        // start together with rst must be ignored
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("rst.busy", busy, 0);
        check_eq("rst.done", done, 0);
        check_eq("rst.addr", addr, 0);
        check_eq("rst.fpu_en", fpu_en, 0);
        check_eq("rst.wr_en", wr_en, 0);
        check_eq("rst.mcnt", mismatch_cnt, 0);
        check_eq("rst.tcnt", timeout_cnt, 0);
        check_eq("rst.fv", fail_valid, 0);
        check_eq("rst.ffa", first_fail_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle.busy", busy, 0);

        run_vectors("ideal", 1'b0);

        set_ideal();
        bad_lane[2] = 5; bad_bit[2] = 40;
        run_vectors("flip", 1'b0);

        set_ideal();
        d_arr[1] = 0;
        run_vectors("hang", 1'b0);

        set_ideal();
        run_vectors("midstart", 1'b1);

        // reset while waiting for ready at addr 2
        set_ideal();
        lane_vec = 0;
        pulse_start();
        nfe = 0;
        for (int cyc = 0; cyc < 200 && nfe < 3; cyc++) begin
            if (fpu_en) nfe++;
            if (nfe < 3) @(negedge clk);
        end
        check_eq("abort.reached", nfe, 3);
        @(negedge clk);
        check_eq("abort.addr_before", addr, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort.busy", busy, 0);
        check_eq("abort.addr", addr, 0);
        check_eq("abort.wr_en", wr_en, 0);
        check_eq("abort.fpu_en", fpu_en, 0);
        check_eq("abort.done", done, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq($sformatf("abort.quiet%0d", i), {fpu_en, wr_en, busy}, 0);
        end
        run_vectors("rerun", 1'b0);

        set_ideal();
        stuck0 = 1'b1;
        run_vectors("stuck", 1'b0);

        for (int r = 0; r < 8; r++) begin
            set_random();
            run_vectors($sformatf("rand%0d", r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_lane_sequencer.md
# fpu_lane_sequencer

Sequencer for the replicated-FPU verification harness. It steps the shared vector address through the operand/rmode/opcode ROMs, issues one enable pulse per vector to all FPU lanes, and waits for the lane-0 ready edge or a timeout. It then cross-checks every lane's result against lane 0 and strobes the per-lane result RAMs. It replaces the free-running address counter and the bare ready-pulse feedback loop with a bounded, observable run controller.

## Interface
- ADDR_W, 12, vector address width
- NUM_VEC, 4096, vectors per run (1..2^ADDR_W)
- LANES, 8, FPU replicas checked
- RES_W, 70, result word per lane (bit 5 = ready)
- ROM_LAT, 1, cycles from address change to valid ROM data (1..3)
- TIMEOUT, 255, max wait cycles for ready after issue (1..1023)

Ports:
- clk  in  1  PLL clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle run request (keypress pulse)
- addr  out  ADDR_W  shared ROM/RAM address
- fpu_en  out  1  enable pulse to all FPU lanes
- lane_ready  in  LANES  ready bit of each lane
- lane_result  in  LANES*RES_W  concatenated lane results, lane 0 in LSBs
- wr_en  out  1  write strobe to all lane RAMs
- busy  out  1  run in progress
- done  out  1  run complete, held until next start or rst
- mismatch_cnt  out  ADDR_W+1  vectors with lane disagreement, saturating
- timeout_cnt  out  ADDR_W+1  vectors that timed out, saturating
- fail_valid  out  1  a first failure has been captured
- first_fail_addr  out  ADDR_W  address of first mismatch or timeout

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, CHECK, WRITE, ADVANCE, DONE.
- IDLE/DONE + start: clear addr, counters, fail_valid and done, then go to FETCH. start is ignored in all other states.
- FETCH: hold for ROM_LAT cycles using a wait counter, then go to ISSUE.
- ISSUE: fpu_en=1 for exactly one cycle. Load the timeout counter with TIMEOUT. Go to WAIT.
- WAIT: on the rising edge of lane_ready[0], go to CHECK. If the counter reaches 0 first, set the timeout flag and go to CHECK.
- CHECK: mismatch = any lane_result[i] != lane_result[0], or any lane_ready bit = 0. Register the mismatch and timeout flags. Go to WRITE.
- WRITE: wr_en=1 for one cycle with addr unchanged. The write happens even on timeout. Go to ADVANCE.
- ADVANCE: increment mismatch_cnt and timeout_cnt if their flags are set; both counters saturate at all-ones. On the first flagged vector, capture addr into first_fail_addr and set fail_valid. If addr == NUM_VEC-1, go to DONE. Otherwise addr+1 and go to FETCH.
- A timed-out vector counts only in timeout_cnt, not in mismatch_cnt.
- The ready edge is detected against a registered copy of lane_ready[0]. The registered copy updates every cycle in every state, so a level left high from the previous vector never produces an edge.

## Timing
- Reset values: state IDLE; addr 0; fpu_en, wr_en, busy, done, fail_valid 0; both counters 0; first_fail_addr 0.
- Reset asserted mid-run aborts on the next edge with no further fpu_en or wr_en.
- busy=1 in every state except IDLE and DONE.
- Per-vector latency is ROM_LAT + 1 (ISSUE) + k (WAIT) + 3 cycles.
  - k = cycles from entering WAIT until the edge is seen, between 1 and TIMEOUT.
- fpu_en and wr_en are never high in the same cycle.
- addr is stable from FETCH through WRITE.
- start in the same cycle as rst: rst wins.
- NUM_VEC = 2^ADDR_W: addr does not wrap; the run ends at all-ones.

## Structure
- Package fpu_test_pkg holds:
  - state enum
  - default LANES, RES_W, ADDR_W
  - READY_BIT = 5 constant
- One sub-module, ready_edge: registered rising-edge detector with synchronous clear.
- Lane comparison is a generate loop inside the top block.

## Test plan
- Ideal lanes with ready 3 cycles after fpu_en, NUM_VEC=4, ROM_LAT=1:
  - exactly 4 fpu_en and 4 wr_en pulses at addr 0,1,2,3
  - done=1, both counters 0, 10 cycles per vector
- Lane 5 result bit 40 flipped at addr 2 only:
  - mismatch_cnt=1, first_fail_addr=2, fail_valid=1
- Ready never rises at addr 1 with TIMEOUT=8:
  - WAIT lasts 8 cycles, timeout_cnt=1, wr_en still pulses at addr 1
  - run continues to addr 3
- rst asserted while in WAIT at addr 2:
  - next cycle state IDLE, addr 0, busy 0, no wr_en
  - a subsequent start reruns from addr 0
- start pulsed during a run: ignored. start after DONE: counters clear, run repeats.
- lane_ready[0] held high across vectors:
  - no false edge; every vector times out and timeout_cnt=NUM_VEC
